// File: rtl/prog1_pkg.sv
// Shared definitions for program 1: Hamming(16,11) SECDED encoder constants,
// FSM state encoding and the reference encode function used by the datapath.
package prog1_pkg;

    localparam int NUM_MSG  = 15;
    localparam int IN_BASE  = 0;
    localparam int OUT_BASE = 30;
    localparam int DM_DEPTH = 256;
    localparam int RF_DEPTH = 8;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    // Register-file slot assignments.
    localparam logic [RF_AW-1:0] R_IN_LO  = 3'd0;
    localparam logic [RF_AW-1:0] R_IN_HI  = 3'd1;
    localparam logic [RF_AW-1:0] R_ENC_LO = 3'd4;
    localparam logic [RF_AW-1:0] R_ENC_HI = 3'd5;
    localparam logic [RF_AW-1:0] R_IDX    = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        ENC   = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Output packing: {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}.
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = ^{d[11], d[10], d[9], d[8], d[4], d[3], d[2]};
        p2 = ^{d[11], d[10], d[7], d[6], d[4], d[3], d[1]};
        p1 = ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]};
        p0 = ^{d[11:1], p8, p4, p2, p1};
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: asynchronous read, synchronous write. Never cleared,
// so contents loaded before a run survive reset.
module data_mem
    import prog1_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] raddr,
    output logic [7:0] rdata,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata
);

    logic [7:0] core [DM_DEPTH];

    assign rdata = core[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            core[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/hamming_enc11.sv
// Combinational Hamming(16,11) SECDED encoder wrapping the package function.
module hamming_enc11
    import prog1_pkg::*;
(
    input  logic [10:0] d,
    output logic [15:0] code
);

    assign code = hamming_encode(d);

endmodule

// File: rtl/reg_file.sv
// Eight-entry byte register file with two write ports and three async read
// ports; synchronously cleared on reset.
module reg_file
    import prog1_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we_a,
    input  logic [RF_AW-1:0] wa_a,
    input  logic [7:0]       wd_a,
    input  logic             we_b,
    input  logic [RF_AW-1:0] wa_b,
    input  logic [7:0]       wd_b,
    input  logic [RF_AW-1:0] ra_a,
    output logic [7:0]       rd_a,
    input  logic [RF_AW-1:0] ra_b,
    output logic [7:0]       rd_b,
    input  logic [RF_AW-1:0] ra_c,
    output logic [7:0]       rd_c
);

    logic [7:0] core [RF_DEPTH];

    assign rd_a = core[ra_a];
    assign rd_b = core[ra_b];
    assign rd_c = core[ra_c];

    // Port b is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                core[i] <= 8'h00;
            end
        end else begin
            if (we_a) core[wa_a] <= wd_a;
            if (we_b) core[wa_b] <= wd_b;
        end
    end

endmodule

// File: rtl/top_level_hamming.sv
// Program 1 top: on reset, encodes NUM_MSG 11-bit messages from data memory and
// writes the 16-bit codewords back, one FSM state per cycle, then raises done.
module top_level_hamming
    import prog1_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic done
);

    state_t state, state_next;
    logic   done_next;

    logic [7:0]       dm_raddr, dm_rdata, dm_waddr, dm_wdata;
    logic             dm_we;
    logic             rf_we_a, rf_we_b;
    logic [RF_AW-1:0] rf_wa_a, rf_wa_b, rf_ra_a, rf_ra_b, rf_ra_c;
    logic [7:0]       rf_wd_a, rf_wd_b, rf_rd_a, rf_rd_b, rf_rd_c;
    logic [15:0]      code;
    logic [7:0]       idx, msg_off, in_lo_addr, out_lo_addr;
    logic             unused_hi_bits;

    data_mem dm1 (
        .clk   (clk),
        .raddr (dm_raddr),
        .rdata (dm_rdata),
        .we    (dm_we),
        .waddr (dm_waddr),
        .wdata (dm_wdata)
    );

    reg_file rf1 (
        .clk   (clk),
        .reset (reset),
        .we_a  (rf_we_a),
        .wa_a  (rf_wa_a),
        .wd_a  (rf_wd_a),
        .we_b  (rf_we_b),
        .wa_b  (rf_wa_b),
        .wd_b  (rf_wd_b),
        .ra_a  (rf_ra_a),
        .rd_a  (rf_rd_a),
        .ra_b  (rf_ra_b),
        .rd_b  (rf_rd_b),
        .ra_c  (rf_ra_c),
        .rd_c  (rf_rd_c)
    );

    // Only d11..d9 of the high input byte carry data; the rest is don't-care.
    hamming_enc11 u_enc (
        .d    ({rf_rd_b[2:0], rf_rd_a}),
        .code (code)
    );
    assign unused_hi_bits = ^rf_rd_b[7:3];

    assign idx         = rf_rd_c;
    assign msg_off     = {idx[6:0], 1'b0};
    assign in_lo_addr  = 8'(IN_BASE) + msg_off;
    assign out_lo_addr = 8'(OUT_BASE) + msg_off;

    // Reset holds the machine at RD_LO so the first active edge reads message 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RD_LO;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = done;
        dm_raddr   = in_lo_addr;
        dm_we      = 1'b0;
        dm_waddr   = out_lo_addr;
        dm_wdata   = 8'h00;
        rf_we_a    = 1'b0;
        rf_wa_a    = R_IN_LO;
        rf_wd_a    = 8'h00;
        rf_we_b    = 1'b0;
        rf_wa_b    = R_IDX;
        rf_wd_b    = 8'h00;
        rf_ra_a    = R_IN_LO;
        rf_ra_b    = R_IN_HI;
        rf_ra_c    = R_IDX;

        unique case (state)
            IDLE: begin
                state_next = RD_LO;
            end
            RD_LO: begin
                rf_we_a    = 1'b1;
                rf_wa_a    = R_IN_LO;
                rf_wd_a    = dm_rdata;
                state_next = RD_HI;
            end
            RD_HI: begin
                dm_raddr   = in_lo_addr + 8'd1;
                rf_we_a    = 1'b1;
                rf_wa_a    = R_IN_HI;
                rf_wd_a    = dm_rdata;
                state_next = ENC;
            end
            ENC: begin
                rf_we_a    = 1'b1;
                rf_wa_a    = R_ENC_LO;
                rf_wd_a    = code[7:0];
                rf_we_b    = 1'b1;
                rf_wa_b    = R_ENC_HI;
                rf_wd_b    = code[15:8];
                state_next = WR_LO;
            end
            WR_LO: begin
                rf_ra_a    = R_ENC_LO;
                dm_we      = 1'b1;
                dm_wdata   = rf_rd_a;
                state_next = WR_HI;
            end
            WR_HI: begin
                rf_ra_a  = R_ENC_HI;
                dm_we    = 1'b1;
                dm_waddr = out_lo_addr + 8'd1;
                dm_wdata = rf_rd_a;
                if (idx == 8'(NUM_MSG - 1)) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    rf_we_b    = 1'b1;
                    rf_wa_b    = R_IDX;
                    rf_wd_b    = idx + 8'd1;
                    state_next = RD_LO;
                end
            end
            DONE: begin
                done_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_top_level_hamming.sv
// Self-checking bench for top_level_hamming: positional Hamming model, random
// and directed messages, mid-run reset abort and rerun from DONE.
module tb_top_level_hamming;

    localparam int NUM_MSG  = 15;
    localparam int OUT_BASE = 30;
    localparam int LATENCY  = 75;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] msg  [NUM_MSG];
    logic [4:0]  junk [NUM_MSG];
    logic [15:0] exp_q [$];

    top_level_hamming dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Classic Hamming layout: codeword bit k is position k, parity at powers of
    // two, data d1..d11 fill the remaining positions in order; bit 0 is overall parity.
    function automatic logic [15:0] ref_encode(input logic [10:0] m);
        logic [15:0] w;
        logic        par;
        int          j;
        w = '0;
        j = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = m[j];
                j++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if ((pos & (pos - 1)) != 0 && ((pos >> b) & 1) == 1) par ^= w[pos];
            end
            w[1 << b] = par;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    task automatic randomize_msgs();
        for (int i = 0; i < NUM_MSG; i++) begin
            msg[i]  = 11'($urandom_range(0, 2047));
            junk[i] = 5'($urandom_range(0, 31));
        end
    endtask

    // Loads inputs and poisons the output window so missing writes show up.
    task automatic load_mem();
        for (int i = 0; i < NUM_MSG; i++) begin
            dut.dm1.core[2*i]     = msg[i][7:0];
            dut.dm1.core[2*i + 1] = {junk[i], msg[i][10:8]};
        end
        for (int k = OUT_BASE; k < 64; k++) dut.dm1.core[k] = 8'hA5;
    endtask

    task automatic pulse_reset(input string tag);
        logic [7:0] rf_or;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rf_or = '0;
        for (int k = 0; k < 8; k++) rf_or |= dut.rf1.core[k];
        check({tag, "_rst_done"}, 16'(done), 16'h0);
        check({tag, "_rst_rf"}, 16'(rf_or), 16'h0);
        reset = 1'b0;
    endtask

    task automatic run_check(input string tag);
        int cnt;
        int changed;
        logic [15:0] exp_w, last_w;
        pulse_reset(tag);
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 16'(cnt), 16'(LATENCY));
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, 16'(done), 16'h1);

        for (int i = 0; i < NUM_MSG; i++) exp_q.push_back(ref_encode(msg[i]));
        last_w = '0;
        for (int i = 0; i < NUM_MSG; i++) begin
            exp_w  = exp_q.pop_front();
            last_w = exp_w;
            check($sformatf("%s_word%0d", tag, i),
                  {dut.dm1.core[OUT_BASE + 2*i + 1], dut.dm1.core[OUT_BASE + 2*i]}, exp_w);
        end

        changed = 0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if (dut.dm1.core[2*i] !== msg[i][7:0]) changed++;
            if (dut.dm1.core[2*i + 1] !== {junk[i], msg[i][10:8]}) changed++;
        end
        for (int k = 60; k < 64; k++) if (dut.dm1.core[k] !== 8'hA5) changed++;
        check({tag, "_mem_untouched"}, 16'(changed), 16'h0);
        check({tag, "_r6"}, 16'(dut.rf1.core[6]), 16'd14);
        check({tag, "_r5r4"}, {dut.rf1.core[5], dut.rf1.core[4]}, last_w);
    endtask

    initial begin
        int seen_done;

        // All-zero messages.
        for (int i = 0; i < NUM_MSG; i++) begin
            msg[i]  = '0;
            junk[i] = '0;
        end
        load_mem();
        run_check("zero");

        // Directed corner messages plus random filler.
        randomize_msgs();
        msg[0] = 11'h7FF; junk[0] = 5'h00;
        msg[1] = 11'h001; junk[1] = 5'h00;
        msg[2] = 11'h400; junk[2] = 5'h00;
        msg[3] = 11'h400; junk[3] = 5'h1F;
        load_mem();
        run_check("directed");
        check("m7ff", {dut.dm1.core[31], dut.dm1.core[30]}, 16'hFFFF);
        check("m001", {dut.dm1.core[33], dut.dm1.core[32]}, 16'h000F);
        check("m400", {dut.dm1.core[35], dut.dm1.core[34]}, 16'h8117);
        check("m400_junk", {dut.dm1.core[37], dut.dm1.core[36]}, 16'h8117);

        // Fully random run.
        randomize_msgs();
        load_mem();
        run_check("random");

        // Abort at cycle 20 of a run, then a full run.
        randomize_msgs();
        load_mem();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done++;
        end
        check("midrun_done_low", 16'(seen_done), 16'h0);
        run_check("midrun");

        // Reset from DONE: rerun must reproduce identical outputs.
        for (int k = OUT_BASE; k < 64; k++) dut.dm1.core[k] = 8'hA5;
        run_check("rerun");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
